// File: rtl/xif_mem_arbiter.sv
// Round-robin arbiter sharing one X-interface memory read channel among NUM_REQ engines.
// One outstanding read at a time; result routed to its owner by latched id, with a timeout abort.
module xif_mem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*32-1:0]   req_addr_i,
  input  logic [NUM_REQ*ID_W-1:0] req_id_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [31:0]             mem_addr_o,
  output logic [ID_W-1:0]         mem_id_o,
  input  logic                    mem_result_valid_i,
  input  logic [ID_W-1:0]         mem_result_id_i,
  input  logic [31:0]             mem_result_rdata_i,
  output logic                    busy_o,
  output logic                    id_mismatch_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [31:0]      addr_q;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_hit;
  logic             match;
  logic             foreign;
  logic             grant_found;
  logic             grant_fire;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [SUM_W-1:0] scan_sum;
  logic [IDX_W-1:0] next_ptr;

  logic [31:0]     addr_arr [NUM_REQ];
  logic [ID_W-1:0] id_arr   [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr_i[g*32 +: 32];
      assign id_arr[g]   = req_id_i[g*ID_W +: ID_W];
    end
  endgenerate

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (scan_sum >= SUM_W'(NUM_REQ)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // No grant in the response-pulse cycle, so transactions never overlap.
  assign grant_fire = (state == S_IDLE) && (rsp_valid_o == '0) && grant_found;

  always_comb begin
    req_ready_o = '0;
    if (grant_fire && !rst_i) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign match       = (state == S_WAIT) && mem_result_valid_i && (mem_result_id_i == id_q);
  assign foreign     = mem_result_valid_i && !match;
  assign cnt_next    = cnt + 1'b1;
  assign timeout_hit = (cnt_next == CNT_W'(TIMEOUT));
  assign next_ptr    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign mem_valid_o = (state == S_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_id_o    = id_q;
  assign busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      addr_q        <= '0;
      id_q          <= '0;
      cnt           <= '0;
      rsp_valid_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_rdata_o   <= '0;
      id_mismatch_o <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      if (foreign) begin
        id_mismatch_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            addr_q <= addr_arr[grant_idx];
            id_q   <= id_arr[grant_idx];
            owner  <= grant_idx;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready_i) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A matching result takes priority over an expiring counter.
          if (match) begin
            rsp_rdata_o        <= mem_result_rdata_i;
            rsp_valid_o[owner] <= 1'b1;
            rr_ptr             <= next_ptr;
            state              <= S_IDLE;
          end else if (timeout_hit) begin
            cnt                <= cnt_next;
            rsp_rdata_o        <= '0;
            rsp_err_o          <= 1'b1;
            rsp_valid_o[owner] <= 1'b1;
            rr_ptr             <= next_ptr;
            state              <= S_IDLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_mem_arbiter.sv
// Directed self-checking bench for xif_mem_arbiter (NUM_REQ=2, ID_W=4, TIMEOUT=8).
module tb_xif_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [7:0]  req_id;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_id;
  logic        res_valid;
  logic [3:0]  res_id;
  logic [31:0] res_rdata;
  logic        busy;
  logic        id_mismatch;

  int passed = 0;
  int total  = 0;

  xif_mem_arbiter #(.NUM_REQ(2), .ID_W(4), .TIMEOUT(8)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_valid_i        (req_valid),
    .req_addr_i         (req_addr),
    .req_id_i           (req_id),
    .req_ready_o        (req_ready),
    .rsp_valid_o        (rsp_valid),
    .rsp_err_o          (rsp_err),
    .rsp_rdata_o        (rsp_rdata),
    .mem_valid_o        (mem_valid),
    .mem_ready_i        (mem_ready),
    .mem_addr_o         (mem_addr),
    .mem_id_o           (mem_id),
    .mem_result_valid_i (res_valid),
    .mem_result_id_i    (res_id),
    .mem_result_rdata_i (res_rdata),
    .busy_o             (busy),
    .id_mismatch_o      (id_mismatch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_id    = {4'h6, 4'h3};
    mem_ready = 1'b0;
    res_valid = 1'b0;
    res_id    = 4'h0;
    res_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_id    = {4'h6, 4'h3};
    mem_ready = 1'b0;
    res_valid = 1'b0;
    res_id    = 4'h0;
    res_rdata = 32'h0;
    tick();
    total++;
    if ({busy, mem_valid, rsp_err, id_mismatch} !== 4'b0000)
      $display("FAIL reset_flags got %b exp 0000", {busy, mem_valid, rsp_err, id_mismatch});
    else passed++;
    total++;
    if ({req_ready, rsp_valid} !== 4'b0000)
      $display("FAIL reset_vectors got %b exp 0000", {req_ready, rsp_valid});
    else passed++;
    total++;
    if ({rsp_rdata, mem_addr, mem_id} !== 68'h0)
      $display("FAIL reset_data got %h exp 0", {rsp_rdata, mem_addr, mem_id});
    else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    mem_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL single_grant got %b exp 01", req_ready);
    else passed++;
    tick();
    total++;
    if ({mem_valid, mem_addr, mem_id, req_ready} !== {1'b1, 32'h0000_1000, 4'h3, 2'b00})
      $display("FAIL single_memreq got %b/%h/%h/%b exp 1/00001000/3/00", mem_valid, mem_addr, mem_id, req_ready);
    else passed++;
    req_valid = 2'b00;
    tick();
    total++;
    if ({mem_valid, busy} !== 2'b01) $display("FAIL single_wait got %b exp 01", {mem_valid, busy});
    else passed++;
    tick();
    res_valid = 1'b1;
    res_id    = 4'h3;
    res_rdata = 32'hDEAD_BEEF;
    tick();
    res_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, busy} !== 4'b0100)
      $display("FAIL single_rsp got %b exp 0100", {rsp_valid, rsp_err, busy});
    else passed++;
    total++;
    if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata got %h exp deadbeef", rsp_rdata);
    else passed++;
    tick();
    total++;
    if ({rsp_valid, rsp_rdata} !== {2'b00, 32'hDEAD_BEEF})
      $display("FAIL single_hold got %b/%h exp 00/deadbeef", rsp_valid, rsp_rdata);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  oh;
    logic [31:0] eaddr;
    do_reset();
    req_valid = 2'b11;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      oh    = (k % 2 == 0) ? 2'b01 : 2'b10;
      eaddr = (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      #1;
      total++;
      if (req_ready !== oh) $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, oh);
      else passed++;
      tick();
      total++;
      if (mem_addr !== eaddr) $display("FAIL rr_addr%0d got %h exp %h", k, mem_addr, eaddr);
      else passed++;
      tick();
      res_valid = 1'b1;
      res_id    = (k % 2 == 0) ? 4'h3 : 4'h6;
      res_rdata = 32'hA000_0000 + 32'(k);
      tick();
      res_valid = 1'b0;
      total++;
      if ({rsp_valid, rsp_rdata} !== {oh, 32'hA000_0000 + 32'(k)})
        $display("FAIL rr_rsp%0d got %b/%h exp %b/%h", k, rsp_valid, rsp_rdata, oh, 32'hA000_0000 + 32'(k));
      else passed++;
      total++;
      if (req_ready !== 2'b00) $display("FAIL rr_no_overlap%0d got %b exp 00", k, req_ready);
      else passed++;
      if (k < 3) tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_ready_stall();
    req_valid = 2'b01;
    mem_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL stall_grant got %b exp 01", req_ready);
    else passed++;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({mem_valid, mem_addr, mem_id, rsp_valid} !== {1'b1, 32'h0000_1000, 4'h3, 2'b00})
        $display("FAIL stall_hold%0d got %b/%h/%h/%b exp 1/00001000/3/00", i, mem_valid, mem_addr, mem_id, rsp_valid);
      else passed++;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if ({rsp_valid, busy} !== 3'b001) $display("FAIL stall_wait%0d got %b exp 001", i, {rsp_valid, busy});
      else passed++;
    end
    res_valid = 1'b1;
    res_id    = 4'h3;
    res_rdata = 32'h1234_5678;
    tick();
    res_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h1234_5678})
      $display("FAIL edge_result_wins got %b/%b/%h exp 01/0/12345678", rsp_valid, rsp_err, rsp_rdata);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    req_valid = 2'b10;
    mem_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL to_grant got %b exp 10", req_ready);
    else passed++;
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if ({rsp_valid, busy} !== 3'b001) $display("FAIL to_wait%0d got %b exp 001", i, {rsp_valid, busy});
      else passed++;
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, busy} !== 4'b1010)
      $display("FAIL to_rsp got %b exp 1010", {rsp_valid, rsp_err, busy});
    else passed++;
    total++;
    if (rsp_rdata !== 32'h0) $display("FAIL to_rdata got %h exp 00000000", rsp_rdata);
    else passed++;
    total++;
    if (id_mismatch !== 1'b0) $display("FAIL to_no_mismatch got %b exp 0", id_mismatch);
    else passed++;
    res_valid = 1'b1;
    res_id    = 4'h6;
    res_rdata = 32'h5555_5555;
    tick();
    res_valid = 1'b0;
    total++;
    if ({id_mismatch, rsp_valid} !== 3'b100)
      $display("FAIL to_late_result got %b exp 100", {id_mismatch, rsp_valid});
    else passed++;
    tick();
  endtask

  task automatic test_mismatch();
    do_reset();
    total++;
    if (id_mismatch !== 1'b0) $display("FAIL mm_cleared got %b exp 0", id_mismatch);
    else passed++;
    req_valid = 2'b01;
    mem_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    res_valid = 1'b1;
    res_id    = 4'h5;
    res_rdata = 32'h0000_0BAD;
    tick();
    total++;
    if ({id_mismatch, rsp_valid, busy} !== 4'b1001)
      $display("FAIL mm_foreign got %b exp 1001", {id_mismatch, rsp_valid, busy});
    else passed++;
    res_id    = 4'h3;
    res_rdata = 32'hCAFE_F00D;
    tick();
    res_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, id_mismatch} !== {2'b01, 1'b0, 32'hCAFE_F00D, 1'b1})
      $display("FAIL mm_deliver got %b/%b/%h/%b exp 01/0/cafef00d/1", rsp_valid, rsp_err, rsp_rdata, id_mismatch);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10;
    mem_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL rm_in_wait got %b exp 1", busy);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, mem_valid, rsp_valid, req_ready, id_mismatch, rsp_err} !== 7'b0)
      $display("FAIL rm_async_clear got %b exp 0000000", {busy, mem_valid, rsp_valid, req_ready, id_mismatch, rsp_err});
    else passed++;
    total++;
    if (rsp_rdata !== 32'h0) $display("FAIL rm_rdata got %h exp 00000000", rsp_rdata);
    else passed++;
    tick();
    rst = 1'b0;
    res_valid = 1'b1;
    res_id    = 4'h6;
    res_rdata = 32'h7777_7777;
    tick();
    res_valid = 1'b0;
    total++;
    if ({rsp_valid, id_mismatch} !== 3'b001)
      $display("FAIL rm_stale_result got %b exp 001", {rsp_valid, id_mismatch});
    else passed++;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL rm_first_grant got %b exp 01", req_ready);
    else passed++;
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ready_stall();
    test_timeout();
    test_mismatch();
    test_reset_mid();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
